// File: rtl/aes_sbox_stream_cipher_wide.sv
// Multi-lane AES S-box stream cipher: each beat XORs LANES bytes with SBOX(key ^ position), 2-stage valid/ready pipe.
// Optional feature: define STREAM_CIPHER_BYPASS_EN to add a per-beat bypass input (pass-through, position frozen).
module aes_sbox_stream_cipher_wide #(
    parameter int LANES = 4,
    parameter int KEY_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_load,
    input  logic [KEY_W-1:0]   simmetric_key,
`ifdef STREAM_CIPHER_BYPASS_EN
    input  logic               bypass,
`endif
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [8*LANES-1:0] txt_in,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [8*LANES-1:0] txt_out,
    output logic [7:0]         pos
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [KEY_W-1:0]   key_q;
    logic [KEY_W-1:0]   keyEff;
    logic [7:0]         pos_q;
    logic [7:0]         pos_d;
    logic [7:0]         posEff;
    logic               s1Valid_q;
    logic               s2Valid_q;
    logic [8*LANES-1:0] s1Data_q;
    logic [8*LANES-1:0] s1Ks_q;
    logic [8*LANES-1:0] s1Ks_d;
    logic [8*LANES-1:0] s2Data_q;
    logic               s2Load;
    logic               accept;
    logic               bypassEff;

`ifdef STREAM_CIPHER_BYPASS_EN
    assign bypassEff = bypass;
`else
    assign bypassEff = 1'b0;
`endif

    assign s2Load     = !s2Valid_q || dout_ready;
    assign din_ready  = !s1Valid_q || s2Load;
    assign accept     = din_valid && din_ready;
    // A key_load in the same cycle as an accept applies to that beat, starting at position 0.
    assign keyEff     = key_load ? simmetric_key : key_q;
    assign posEff     = key_load ? 8'd0 : pos_q;
    assign dout_valid = s2Valid_q;
    assign txt_out    = s2Data_q;
    assign pos        = pos_q;

    always_comb begin
        s1Ks_d = '0;
        pos_d  = posEff;
        for (int i = 0; i < LANES; i++) begin
            if (!bypassEff) begin
                s1Ks_d[8*i +: 8] = SBOX[keyEff[7:0] ^ (posEff + 8'(i))];
            end
        end
        if (accept && !bypassEff) begin
            pos_d = posEff + 8'(LANES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= '0;
            pos_q     <= '0;
            s1Valid_q <= 1'b0;
            s2Valid_q <= 1'b0;
            s1Data_q  <= '0;
            s1Ks_q    <= '0;
            s2Data_q  <= '0;
        end else begin
            key_q <= keyEff;
            pos_q <= pos_d;
            // Data registers only capture on a real handshake so idle-bus garbage never reaches the output.
            if (accept) begin
                s1Valid_q <= 1'b1;
                s1Data_q  <= txt_in;
                s1Ks_q    <= s1Ks_d;
            end else if (s2Load) begin
                s1Valid_q <= 1'b0;
            end
            if (s2Load) begin
                s2Valid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    s2Data_q <= s1Data_q ^ s1Ks_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_sbox_stream_cipher_wide.sv
// Self-checking bench for aes_sbox_stream_cipher_wide: scoreboard model built from a GF(2^8) S-box derivation.
// Exercises STREAM_CIPHER_BYPASS_EN behaviour only when that macro is defined.
`timescale 1ns/1ps
module tb_aes_sbox_stream_cipher_wide;
    localparam int LANES = 4;
    localparam int W     = 8 * LANES;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [7:0]   simmetric_key;
    logic         bypass;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] txt_in;
    logic         dout_valid;
    logic         dout_ready;
    logic [W-1:0] txt_out;
    logic [7:0]   pos;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int acceptCount = 0;
    bit checkEn = 1'b0;

    logic [7:0]   sboxTab [256];
    logic [W-1:0] expQ [$];
    int           accCycQ [$];
    logic [W-1:0] emitLog [$];
    logic [7:0]   mKey = 8'h00;
    logic [7:0]   mPos = 8'h00;
    logic [W-1:0] pt [64];
    logic [W-1:0] ct [64];

    aes_sbox_stream_cipher_wide #(.LANES(LANES), .KEY_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_load      (key_load),
        .simmetric_key (simmetric_key),
`ifdef STREAM_CIPHER_BYPASS_EN
        .bypass        (bypass),
`endif
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .txt_in        (txt_in),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .txt_out       (txt_out),
        .pos           (pos)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    function automatic logic [7:0] sboxRef(input logic [7:0] v);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        if (v != 8'h00) begin
            for (int c = 1; c < 256; c++) begin
                if (gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
            end
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d, input logic kl,
                                 input logic [7:0] k, input logic rdy, input logic bp);
        rst           = r;
        din_valid     = v;
        txt_in        = d;
        key_load      = kl;
        simmetric_key = k;
        dout_ready    = rdy;
        bypass        = bp;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 8'($urandom), 1'b1, 1'b0);
    endtask

    // Reference model: oldest unsent beat appears exactly 2 cycles after acceptance; at most 2 beats held.
    always @(negedge clk) begin
        logic         expValid;
        logic         expReady;
        logic [7:0]   kE;
        logic [7:0]   pE;
        logic [W-1:0] word;
        expValid = (expQ.size() > 0) && (cycle >= accCycQ[0] + 2);
        expReady = (expQ.size() < 2) || dout_ready;
        if (checkEn) begin
            checkOutput("dout_valid", W'(dout_valid), W'(expValid));
            checkOutput("din_ready", W'(din_ready), W'(expReady));
            checkOutput("pos", W'(pos), W'(mPos));
            if (expValid && dout_valid) checkOutput("txt_out", txt_out, expQ[0]);
        end
        if (dout_valid && dout_ready && !rst) emitLog.push_back(txt_out);
        if (rst) begin
            expQ.delete();
            accCycQ.delete();
            mKey    = 8'h00;
            mPos    = 8'h00;
            checkEn = 1'b1;
        end else begin
            if (expValid && dout_ready) begin
                void'(expQ.pop_front());
                void'(accCycQ.pop_front());
            end
            kE = key_load ? simmetric_key : mKey;
            pE = key_load ? 8'h00 : mPos;
            if (din_valid && expReady) begin
                for (int i = 0; i < LANES; i++) begin
                    word[8*i +: 8] = txt_in[8*i +: 8] ^ (bypass ? 8'h00 : sboxTab[kE ^ (pE + 8'(i))]);
                end
                expQ.push_back(word);
                accCycQ.push_back(cycle);
                acceptCount++;
                if (!bypass) pE = pE + 8'(LANES);
            end
            mKey = kE;
            mPos = pE;
        end
        cycle++;
    end

    initial begin
        int startAcc;
        for (int x = 0; x < 256; x++) sboxTab[x] = sboxRef(8'(x));
        rst = 1'b1; key_load = 1'b0; simmetric_key = 8'h00; bypass = 1'b0;
        din_valid = 1'b0; txt_in = '0; dout_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, then the "ABCD" beat under key 0x12.
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("reset_dout_valid", W'(dout_valid), W'(1'b0));
        checkOutput("reset_txt_out", txt_out, '0);
        checkOutput("reset_din_ready", W'(din_ready), W'(1'b1));
        checkOutput("reset_pos", W'(pos), W'(8'h00));
        applyStimulus(1'b0, 1'b1, 32'h44434241, 1'b1, 8'h12, 1'b1, 1'b0);
        checkOutput("abcd_pos", W'(pos), W'(8'h04));
        checkOutput("abcd_latency1", W'(dout_valid), W'(1'b0));
        applyStimulus(1'b0, 1'b0, $urandom, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("abcd_latency2", W'(dout_valid), W'(1'b1));
        checkOutput("abcd_txt_out", txt_out, 32'hC6893F88);
        drain(3);

        // Round trip: encrypt, reload the key, decrypt the captured ciphertext.
        emitLog.delete();
        for (int i = 0; i < 64; i++) begin
            pt[i] = $urandom;
            applyStimulus(1'b0, 1'b1, pt[i], i == 0, 8'h12, 1'b1, 1'b0);
        end
        drain(4);
        checkOutput("rt_enc_count", W'(emitLog.size()), W'(64));
        for (int i = 0; i < 64; i++) ct[i] = (i < emitLog.size()) ? emitLog[i] : '0;
        emitLog.delete();
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, 1'b1, ct[i], i == 0, 8'h12, 1'b1, 1'b0);
        drain(4);
        checkOutput("rt_dec_count", W'(emitLog.size()), W'(64));
        for (int i = 0; i < 64; i++) begin
            checkOutput("rt_plaintext", (i < emitLog.size()) ? emitLog[i] : '0, pt[i]);
        end

        // Position wrap: 64 beats of four lanes cover all 256 positions.
        emitLog.delete();
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, 1'b1, '0, i == 0, 8'h12, 1'b1, 1'b0);
        checkOutput("wrap_pos", W'(pos), W'(8'h00));
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 8'h00, 1'b1, 1'b0);
        drain(4);
        checkOutput("wrap_beat0", (emitLog.size() > 0) ? emitLog[0] : '0, 32'h82CA7DC9);
        checkOutput("wrap_beat64", (emitLog.size() > 64) ? emitLog[64] : '0, 32'h82CA7DC9);

        // Backpressure with a 30% sink duty and an always-valid source.
        emitLog.delete();
        startAcc = acceptCount;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 8'h00, $urandom_range(0, 99) < 30, 1'b0);
        end
        drain(4);
        checkOutput("bp_count", W'(emitLog.size()), W'(acceptCount - startAcc));

        // Mixed random traffic with occasional key reloads.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, $urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 5,
                          8'($urandom), $urandom_range(0, 99) < 70, 1'b0);
        end
        drain(4);

        // key_load while beat A is still in flight.
        emitLog.delete();
        applyStimulus(1'b0, 1'b1, '0, 1'b1, 8'h12, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, '0, 1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("kl_pos", W'(pos), W'(8'h04));
        drain(4);
        checkOutput("kl_beatA", (emitLog.size() > 0) ? emitLog[0] : '0, 32'h82CA7DC9);
        checkOutput("kl_beatB", (emitLog.size() > 1) ? emitLog[1] : '0, 32'h7B777C63);

        // Reset with two beats held, together with a key_load that must lose.
        applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 8'h12, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 8'h00, 1'b0, 1'b0);
        emitLog.delete();
        applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 8'h77, 1'b0, 1'b0);
        checkOutput("rst_dout_valid", W'(dout_valid), W'(1'b0));
        checkOutput("rst_txt_out", txt_out, '0);
        checkOutput("rst_pos", W'(pos), W'(8'h00));
        checkOutput("rst_din_ready", W'(din_ready), W'(1'b1));
        drain(4);
        checkOutput("rst_no_stale", W'(emitLog.size()), W'(0));
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 8'h00, 1'b1, 1'b0);
        drain(4);
        checkOutput("rst_key_cleared", (emitLog.size() > 0) ? emitLog[0] : '0, 32'h7B777C63);

`ifdef STREAM_CIPHER_BYPASS_EN
        emitLog.delete();
        applyStimulus(1'b0, 1'b1, '0, 1'b1, 8'h12, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("byp_pos", W'(pos), W'(8'h04));
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 8'h00, 1'b1, 1'b0);
        drain(4);
        checkOutput("byp_passthru", (emitLog.size() > 1) ? emitLog[1] : '0, 32'hDEADBEEF);
        checkOutput("byp_next_beat", (emitLog.size() > 2) ? emitLog[2] : '0, 32'h59FAF047);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
